// File: rtl/rv32i_soc_pkg.sv
// Shared constants for the RV32I SoC slice: AXI response codes, the
// IMEM load controller state encoding and control-register bit positions.
package rv32i_soc_pkg;

  // AXI write response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Load controller FSM encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GOT_AW = 3'd1;
  localparam logic [2:0] GOT_W  = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  // Control register bit positions
  localparam int CTRL_RUN_BIT = 0;
  localparam int CTRL_CLR_BIT = 1;

  // Result of decoding one write transaction
  typedef struct packed {
    logic       imem_wr;
    logic       ctrl_wr;
    logic [1:0] resp;
  } dec_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// AXI4-Lite write-only slave that loads the RV32I instruction memory and
// holds the core in reset until the host sets the RUN control bit.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN adds a running XOR
// checksum (rotate-left-1 of each accepted IMEM word) on checksum_o.
//
// The decode is evaluated on the edge that completes the later AW/W
// handshake, using the incoming channel value when that channel completes
// on the same edge. This lets the IMEM strobe be a registered output that
// is high during the EXEC cycle itself.
module imem_load_ctrl
  import rv32i_soc_pkg::*;
#(
  parameter int          RV32I_IMEM_DEPTH = 1,
  parameter logic [31:0] CTRL_ADDR        = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic        s_axi_wr_en_o,
  output logic [31:0] s_axi_addr_o,
  output logic [31:0] s_axi_data_o,
  output logic        cpu_rst_n_o,
  output logic        load_busy_o
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [31:0] checksum_o
`endif
);

  localparam logic [31:0] IMEM_BYTES = 32'(RV32I_IMEM_DEPTH * 1024);

  logic [2:0]  state_r, nxt_state_s;
  logic        awready_r, wready_r, bvalid_r, load_busy_r;
  logic [1:0]  bresp_r, resp_pend_r;
  logic        wr_en_r, run_r, cpu_rst_n_r;
  logic [31:0] addr_o_r, data_o_r;
  logic [31:0] awaddr_r, wdata_r;
  logic [3:0]  wstrb_r;
  logic        aw_hs_s, w_hs_s, enter_exec_s;
  logic [31:0] eff_addr_s, eff_data_s;
  logic [3:0]  eff_strb_s;
  dec_t        dec_s;

  // Address decode with priority IMEM window, control register, unmapped
  function automatic dec_t decode(input logic [31:0] addr,
                                  input logic [3:0]  strb,
                                  input logic        run);
    dec_t d;
    d.imem_wr = 1'b0;
    d.ctrl_wr = 1'b0;
    d.resp    = RESP_DECERR;
    if (addr < IMEM_BYTES) begin
      if ((addr[1:0] == 2'b00) && (strb == 4'hF) && !run) begin
        d.imem_wr = 1'b1;
        d.resp    = RESP_OKAY;
      end else begin
        d.resp    = RESP_SLVERR;
      end
    end else if (addr == CTRL_ADDR) begin
      if (strb[0]) begin
        d.ctrl_wr = 1'b1;
        d.resp    = RESP_OKAY;
      end else begin
        d.resp    = RESP_SLVERR;
      end
    end else begin
      d.resp = RESP_DECERR;
    end
    return d;
  endfunction

`ifdef IMEM_LOAD_CHECKSUM_EN
  // Checksum contribution of one IMEM word
  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction
`endif

  assign aw_hs_s = s_axi_awvalid & awready_r;
  assign w_hs_s  = s_axi_wvalid  & wready_r;

  // Operands seen by the decode: bypass a channel completing this cycle
  always_comb begin
    eff_addr_s = awaddr_r;
    eff_data_s = wdata_r;
    eff_strb_s = wstrb_r;
    if (aw_hs_s) begin
      eff_addr_s = s_axi_awaddr;
    end else begin
      eff_addr_s = awaddr_r;
    end
    if (w_hs_s) begin
      eff_data_s = s_axi_wdata;
      eff_strb_s = s_axi_wstrb;
    end else begin
      eff_data_s = wdata_r;
      eff_strb_s = wstrb_r;
    end
    dec_s = decode(eff_addr_s, eff_strb_s, run_r);
  end

  // Next-state logic of the transaction FSM
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          nxt_state_s = EXEC;
        end else if (aw_hs_s) begin
          nxt_state_s = GOT_AW;
        end else if (w_hs_s) begin
          nxt_state_s = GOT_W;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      GOT_AW: begin
        if (w_hs_s) begin
          nxt_state_s = EXEC;
        end else begin
          nxt_state_s = GOT_AW;
        end
      end
      GOT_W: begin
        if (aw_hs_s) begin
          nxt_state_s = EXEC;
        end else begin
          nxt_state_s = GOT_W;
        end
      end
      EXEC: nxt_state_s = RESP;
      RESP: begin
        if (s_axi_bready) begin
          nxt_state_s = IDLE;
        end else begin
          nxt_state_s = RESP;
        end
      end
      default: nxt_state_s = IDLE;
    endcase
  end

  assign enter_exec_s = (nxt_state_s == EXEC);

  // State register and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      awready_r   <= 1'b0;
      wready_r    <= 1'b0;
      bvalid_r    <= 1'b0;
      load_busy_r <= 1'b0;
    end else begin
      state_r     <= nxt_state_s;
      awready_r   <= (nxt_state_s == IDLE) || (nxt_state_s == GOT_W);
      wready_r    <= (nxt_state_s == IDLE) || (nxt_state_s == GOT_AW);
      bvalid_r    <= (nxt_state_s == RESP);
      load_busy_r <= (nxt_state_s != IDLE);
    end
  end

  // Capture AW and W channel payloads on their handshakes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awaddr_r <= 32'h0;
      wdata_r  <= 32'h0;
      wstrb_r  <= 4'h0;
    end else begin
      if (aw_hs_s) begin
        awaddr_r <= s_axi_awaddr;
      end
      if (w_hs_s) begin
        wdata_r <= s_axi_wdata;
        wstrb_r <= s_axi_wstrb;
      end
    end
  end

  // Execute the decoded write: IMEM strobe, RUN update and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_r     <= 1'b0;
      addr_o_r    <= 32'h0;
      data_o_r    <= 32'h0;
      resp_pend_r <= RESP_OKAY;
      bresp_r     <= RESP_OKAY;
      run_r       <= 1'b0;
      cpu_rst_n_r <= 1'b0;
    end else begin
      wr_en_r <= enter_exec_s & dec_s.imem_wr;
      if (enter_exec_s && dec_s.imem_wr) begin
        addr_o_r <= eff_addr_s;
        data_o_r <= eff_data_s;
      end
      if (enter_exec_s) begin
        resp_pend_r <= dec_s.resp;
      end
      if (enter_exec_s && dec_s.ctrl_wr) begin
        run_r <= eff_data_s[CTRL_RUN_BIT];
      end
      if (state_r == EXEC) begin
        bresp_r <= resp_pend_r;
      end
      cpu_rst_n_r <= run_r;
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] checksum_r;

  // Running checksum of accepted IMEM words, cleared by control bit 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_r <= 32'h0;
    end else if (enter_exec_s && dec_s.imem_wr) begin
      checksum_r <= checksum_r ^ rotl1(eff_data_s);
    end else if (enter_exec_s && dec_s.ctrl_wr && eff_data_s[CTRL_CLR_BIT]) begin
      checksum_r <= 32'h0;
    end
  end

  assign checksum_o = checksum_r;
`endif

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_wr_en_o = wr_en_r;
  assign s_axi_addr_o  = addr_o_r;
  assign s_axi_data_o  = data_o_r;
  assign cpu_rst_n_o   = cpu_rst_n_r;
  assign load_busy_o   = load_busy_r;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed self-checking bench for imem_load_ctrl. Expected IMEM writes and
// B responses are queued when a transaction is issued and retired when the
// DUT produces them. Checksum checks compile in with IMEM_LOAD_CHECKSUM_EN.
module tb_imem_load_ctrl;

  localparam logic [31:0] CTRL = 32'h0001_0000;
  localparam logic [1:0]  OKAY = 2'b00;
  localparam logic [1:0]  SLV  = 2'b10;
  localparam logic [1:0]  DEC  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic        s_axi_wr_en_o;
  logic [31:0] s_axi_addr_o;
  logic [31:0] s_axi_data_o;
  logic        cpu_rst_n_o;
  logic        load_busy_o;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  logic [63:0] wr_q[$];
  logic [1:0]  resp_q[$];

  imem_load_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_wr_en_o (s_axi_wr_en_o),
    .s_axi_addr_o  (s_axi_addr_o),
    .s_axi_data_o  (s_axi_data_o),
    .cpu_rst_n_o   (cpu_rst_n_o),
    .load_busy_o   (load_busy_o)
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    .checksum_o    (checksum_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Retire every IMEM strobe against the expected-write queue
  always @(negedge clk) begin
    if (s_axi_wr_en_o === 1'b1) begin
      logic [63:0] e;
      wr_cnt++;
      chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        chk("wr_addr", s_axi_addr_o, e[63:32]);
        chk("wr_data", s_axi_data_o, e[31:0]);
      end
    end
  end

  // One write transaction; w_lead>0 issues W that many cycles before AW
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input logic [1:0] exp_resp,
                           input logic exp_wr, input int hold);
    int n;
    int wr_before;
    logic aw_done, w_done, aw_hs, w_hs;
    logic [1:0] er;
    wr_before = wr_cnt;
    if (exp_wr) wr_q.push_back({a, d});
    resp_q.push_back(exp_resp);
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_wvalid  = 1'b1;
    s_axi_awvalid = (w_lead == 0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 200) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(negedge clk);
      n++;
      if (aw_hs) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; s_axi_wvalid  = 1'b0; end
      if (w_done && !aw_done && n >= w_lead) s_axi_awvalid = 1'b1;
    end
    chk("handshake_done", 32'(aw_done && w_done), 32'd1);
    chk("wr_en_latency", 32'(s_axi_wr_en_o), 32'(exp_wr));
    chk("busy_exec", 32'(load_busy_o), 32'd1);
    n = 0;
    while (s_axi_bvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bvalid_latency", 32'(n), 32'd1);
    er = resp_q.pop_front();
    chk("bresp", 32'(s_axi_bresp), 32'(er));
    for (int i = 0; i < hold; i++) begin
      s_axi_awaddr  = 32'h0000_0040;
      s_axi_awvalid = 1'b1;
      @(negedge clk);
      chk("hold_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("hold_bresp", 32'(s_axi_bresp), 32'(er));
      chk("hold_awready", 32'(s_axi_awready), 32'd0);
    end
    s_axi_awvalid = 1'b0;
    s_axi_bready  = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk("bvalid_drop", 32'(s_axi_bvalid), 32'd0);
    chk("busy_idle", 32'(load_busy_o), 32'd0);
    chk("awready_idle", 32'(s_axi_awready), 32'd1);
    chk("wr_count", 32'(wr_cnt - wr_before), 32'(exp_wr));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_awready"}, 32'(s_axi_awready), 32'd0);
    chk({tag, "_wready"}, 32'(s_axi_wready), 32'd0);
    chk({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd0);
    chk({tag, "_bresp"}, 32'(s_axi_bresp), 32'd0);
    chk({tag, "_wr_en"}, 32'(s_axi_wr_en_o), 32'd0);
    chk({tag, "_addr"}, s_axi_addr_o, 32'd0);
    chk({tag, "_data"}, s_axi_data_o, 32'd0);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n_o), 32'd0);
    chk({tag, "_busy"}, 32'(load_busy_o), 32'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum_o, 32'd0);
`endif
  endtask

  initial begin
    int wr_before;
    rst_n = 1'b0;
    s_axi_awaddr = 32'h0; s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 32'(s_axi_awready), 32'd1);
    chk("post_rst_wready", 32'(s_axi_wready), 32'd1);

    // Same-cycle AW/W IMEM write
    axi_write(32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, OKAY, 1'b1, 0);
    chk("t1_cpu_held", 32'(cpu_rst_n_o), 32'd0);
    // W five cycles ahead of AW
    axi_write(32'h0000_0008, 32'h1234_5678, 4'hF, 5, OKAY, 1'b1, 0);
    // Last word of the IMEM window
    axi_write(32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 2, OKAY, 1'b1, 0);

    // RUN set blocks IMEM writes; RUN clear holds the core again
    axi_write(CTRL, 32'h0000_0001, 4'h1, 0, OKAY, 1'b0, 0);
    chk("t3_cpu_run", 32'(cpu_rst_n_o), 32'd1);
    axi_write(32'h0000_0000, 32'h1111_1111, 4'hF, 0, SLV, 1'b0, 0);
    axi_write(CTRL, 32'h0000_0000, 4'hF, 0, OKAY, 1'b0, 0);
    chk("t3_cpu_held", 32'(cpu_rst_n_o), 32'd0);

    // Error decodes
    axi_write(32'h0000_0400, 32'h2222_2222, 4'hF, 0, DEC, 1'b0, 0);
    axi_write(32'h0000_0002, 32'h3333_3333, 4'hF, 0, SLV, 1'b0, 0);
    axi_write(32'h0000_0000, 32'h4444_4444, 4'h3, 0, SLV, 1'b0, 0);
    axi_write(CTRL, 32'h0000_0001, 4'hE, 0, SLV, 1'b0, 0);
    chk("t4_ctrl_nostrb", 32'(cpu_rst_n_o), 32'd0);
    axi_write(CTRL + 32'd4, 32'h0000_0001, 4'hF, 0, DEC, 1'b0, 0);

    // Back-pressure on B
    axi_write(32'h0000_0010, 32'h00AA_0055, 4'hF, 0, OKAY, 1'b1, 10);

    // Reset during GOT_AW with the core running
    axi_write(CTRL, 32'h0000_0001, 4'h1, 0, OKAY, 1'b0, 0);
    chk("t6_cpu_run", 32'(cpu_rst_n_o), 32'd1);
    wr_before = wr_cnt;
    s_axi_awaddr = 32'h0000_0020;
    s_axi_awvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    chk("t6_busy_got_aw", 32'(load_busy_o), 32'd1);
    chk("t6_wready_got_aw", 32'(s_axi_wready), 32'd1);
    rst_n = 1'b0;
    s_axi_wdata = 32'h5555_5555;
    s_axi_wstrb = 4'hF;
    s_axi_wvalid = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_values("midrst");
    s_axi_wvalid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("t6_no_wr", 32'(wr_cnt - wr_before), 32'd0);
    chk("t6_cpu_held", 32'(cpu_rst_n_o), 32'd0);

    // RUN cleared by reset, so IMEM writes are accepted again
    axi_write(32'h0000_0020, 32'h0000_0001, 4'hF, 0, OKAY, 1'b1, 0);
    axi_write(32'h0000_0024, 32'h0000_0002, 4'hF, 3, OKAY, 1'b1, 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    chk("ck_accum", checksum_o, 32'h0000_0006);
    axi_write(32'h0000_0028, 32'h8000_0000, 4'hF, 0, OKAY, 1'b1, 0);
    chk("ck_wrap", checksum_o, 32'h0000_0007);
    axi_write(32'h0000_002A, 32'hFFFF_FFFF, 4'hF, 0, SLV, 1'b0, 0);
    chk("ck_no_err_update", checksum_o, 32'h0000_0007);
`endif
    axi_write(CTRL, 32'h0000_0002, 4'hF, 0, OKAY, 1'b0, 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    chk("ck_clear", checksum_o, 32'h0000_0000);
`endif
    chk("final_cpu_held", 32'(cpu_rst_n_o), 32'd0);
    chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
AXI4-Lite write-only slave that sequences host program loads into the RV32I instruction memory. Each accepted word write becomes a single-cycle write strobe on the IMEM write port. The block also holds the CPU core in reset while a program is loaded, and releases it when the host writes the RUN bit of a control register. It sits between the SoC AXI interconnect and the core's IMEM/reset inputs.

Parameters:
RV32I_IMEM_DEPTH, 1, IMEM size in KB; IMEM_BYTES = RV32I_IMEM_DEPTH*1024.
CTRL_ADDR, 32'h0001_0000, byte address of the control register (must be >= IMEM_BYTES).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
s_axi_awaddr  in  32  write address
s_axi_awvalid  in  1  address valid
s_axi_awready  out  1  address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  data valid
s_axi_wready  out  1  data ready
s_axi_bresp  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR
s_axi_bvalid  out  1  response valid
s_axi_bready  in  1  response ready
s_axi_wr_en_o  out  1  IMEM write strobe, one cycle per word
s_axi_addr_o  out  32  IMEM byte address (IMEM slices the word index)
s_axi_data_o  out  32  IMEM write data
cpu_rst_n_o  out  1  core reset, low = held
load_busy_o  out  1  high from AW/W capture until B handshake

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising clk edge.
- Reset values: awready=0, wready=0, bvalid=0, bresp=00, s_axi_wr_en_o=0, addr_o=0, data_o=0, cpu_rst_n_o=0 (core held), RUN=0, load_busy_o=0. The FSM enters IDLE.
- FSM states:
  - IDLE: awready=1, wready=1. AW-only handshake -> GOT_AW. W-only handshake -> GOT_W. Both in the same cycle -> EXEC.
  - GOT_AW: wready=1, awready=0. W handshake -> EXEC.
  - GOT_W: awready=1, wready=0. AW handshake -> EXEC.
  - EXEC: one cycle. Decode the latched addr/data/strb, perform any write, register bresp -> RESP.
  - RESP: bvalid=1, bresp held stable. bready=1 -> IDLE, with bvalid dropping on the next cycle.
- AW and W are captured into registers on their handshake. Channels may arrive in either order, any number of cycles apart.
- Decode in EXEC, with priority:
  1. addr < IMEM_BYTES: requires addr[1:0]==0, wstrb==4'hF and RUN==0. If met, assert s_axi_wr_en_o for exactly this one cycle with addr_o/data_o driven, and return OKAY. If any condition fails, no write and SLVERR.
  2. addr == CTRL_ADDR: wstrb[0] must be 1, otherwise SLVERR and no change. If accepted, RUN <= wdata[0] and return OKAY.
  3. Any other address: DECERR, no side effect.
- cpu_rst_n_o is a registered copy of RUN; it changes on the cycle after EXEC.
- Latency: the IMEM write occurs 1 cycle after the later of the AW/W handshakes. bvalid rises on the following cycle. Minimum transaction is 3 cycles including IDLE.
- Throughput: one outstanding transaction. No AW/W is accepted in EXEC or RESP.
- bvalid held with bready low: stay in RESP indefinitely, with no further acceptance.
- load_busy_o: high in GOT_AW, GOT_W, EXEC and RESP; low in IDLE.
- Reset mid-transaction: the transaction is discarded with no B response. RUN clears, so the core is held again. s_axi_wr_en_o never asserts during or after reset.

Optional Feature:
IMEM_LOAD_CHECKSUM_EN
- Defined:
  - Adds output checksum_o[31:0], reset 0.
  - On every accepted IMEM write, checksum_o <= checksum_o ^ {data[30:0], data[31]}, i.e. the data rotated left by 1.
  - A control write with wdata[1]=1 clears the checksum in the same EXEC cycle; RUN is still updated from wdata[0].
- Undefined: no port and no logic; control bit 1 is ignored.

Decomposition:
- Shared package rv32i_soc_pkg holds:
  - AXI response constants RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - The FSM state encoding (IDLE, GOT_AW, GOT_W, EXEC, RESP).
  - CTRL_RUN_BIT=0 and CTRL_CLR_BIT=1.
- The block is a single module; no sub-module is warranted. The decode is a small combinational function inside it.

Test Plan:
1. Reset, then write 0x0000_0004 = 0xDEADBEEF with strb F, AW and W in the same cycle -> s_axi_wr_en_o pulses 1 cycle with addr_o=4 and data_o=DEADBEEF; bresp=00; cpu_rst_n_o stays 0.
2. W issued 5 cycles before AW (addr 0x8, data 0x12345678) -> wr_en pulses once, the cycle after AW; bresp=00.
3. Write CTRL_ADDR=0x1 -> OKAY and cpu_rst_n_o=1. Then an IMEM write to 0x0 -> SLVERR, no wr_en. Write CTRL_ADDR=0x0 -> cpu_rst_n_o=0.
4. Address 0x400 with depth 1 -> DECERR. Address 0x2 -> SLVERR. strb 4'h3 to 0x0 -> SLVERR. None of these pulse wr_en.
5. bready held low 10 cycles -> bvalid and bresp stable; a new AW is not accepted until the B handshake.
6. rst_n low during GOT_AW -> all outputs return to reset values and no wr_en occurs. With checksum enabled: writes 0x1 then 0x2 -> checksum_o=0x6, and a control write of 0x2 -> checksum_o=0.
